push_button_detector: RTL and testbench
=======================================

Name: push_button_detector

Overview:
- Converts a raw, asynchronous, bouncy push-button level `x` into a single-clock-cycle pulse `z` per debounced press.
- Datapath: synchronizer, then debounce filter, then rising-edge (press) detector FSM.
- Sits between a board button pin and control logic that must see exactly one event per press.

Parameters:
- SYNC_STAGES, 2, number of flip-flop stages synchronizing `x`; minimum 2.
- DEBOUNCE_CYCLES, 16, consecutive cycles the synchronized input must differ from the debounced level before that level flips; minimum 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), width of the debounce counter (derived; not overridden).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- x  input  1  raw push-button level, asynchronous to clk, 1 = pressed.
- z  output  1  registered one-cycle pulse per debounced press.

Behaviour:
- Reset (reset=0, async): all synchronizer flops = 0, debounced level db = 0, counter = 0, FSM = IDLE, z = 0. Release is recognized at the next clk edge.
- Synchronizer: shift chain of SYNC_STAGES flops; s = last stage.
- Debounce, per clock edge:
  - If s == db: counter cleared to 0.
  - Else if counter == DEBOUNCE_CYCLES-1: db <= s and counter <= 0.
  - Else: counter increments.
  - Any bounce shorter than DEBOUNCE_CYCLES cycles is ignored. Both press and release are filtered identically.
- Press FSM (Moore, z decoded from state, registered):
  - IDLE (z=0): db=1 -> PULSE; else stay.
  - PULSE (z=1): db=1 -> HELD; db=0 -> IDLE.
  - HELD (z=0): db=0 -> IDLE; else stay.
- Pulse width is exactly 1 clk cycle regardless of hold length. No further pulse until db has returned to 0 and risen again.
- Latency (SYNC_STAGES=2): z rises on the (DEBOUNCE_CYCLES+3)-th consecutive rising edge at which x is sampled 1, counting the first such edge as 1. Generally: SYNC_STAGES+DEBOUNCE_CYCLES+1.
- x held 1 through reset: after reset release it counts as a fresh press and produces one pulse after the normal latency.
- Reset asserted mid-press or mid-pulse: z drops to 0 immediately (async); no pulse is pending afterwards.
- No overflow: the counter never exceeds DEBOUNCE_CYCLES-1.

Decomposition:
- Shared package: FSM state enum (IDLE, PULSE, HELD, 2-bit encoding 00/01/10) and default DEBOUNCE_CYCLES constant.
- One natural sub-module: pb_debounce (synchronizer plus counter filter, outputs db).
- The top holds the FSM.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
1. Reset: hold reset=0 for 5 cycles with x toggling randomly -> z=0 throughout; release with x=0 -> z stays 0.
2. Clean press: release reset, x=1 held 50 cycles -> z=1 on exactly the 7th edge sampling x=1, for one cycle only, then 0 for the rest of the hold.
3. Bounce filter: x=1 for 3 cycles, then 0, repeated 5 times -> z never asserts. Then x=1 for 10 cycles -> exactly one pulse.
4. Release glitch: during a held press, x=0 for 2 cycles then back to 1 -> no second pulse. A full release of 6+ cycles then x=1 again -> a second single pulse.
5. Async reset mid-pulse: assert reset=0 between edges while z=1 -> z=0 immediately. Release with x=1 -> exactly one new pulse after 7 edges.
6. Two long presses (x=1 for 6000 cycles, x=0 for 25, x=1 for 600, then x=0) -> exactly two pulses total, each 1 cycle wide.

Source files
------------

// File: rtl/push_button_detector_pkg.sv
// Shared types and defaults for the push-button press detector.
package push_button_detector_pkg;

    localparam int unsigned SYNC_STAGES_DEF     = 2;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;

    // Press FSM states; only PULSE has bit 0 set.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PULSE = 2'b01,
        HELD  = 2'b10
    } pb_state_e;

endpackage : push_button_detector_pkg

// File: rtl/push_button_detector_if.sv
// Button-level input and press-pulse output bundled as one port.
interface push_button_detector_if;

    logic x;   // raw button level, asynchronous, 1 = pressed
    logic z;   // one-cycle pulse per debounced press

    modport master (output x, input  z);
    modport slave  (input  x, output z);

endinterface : push_button_detector_if

// File: rtl/push_button_detector_pb_debounce.sv
// Synchronizer chain followed by a consecutive-cycle debounce filter.
module pb_debounce
    import push_button_detector_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_x,
    output logic o_db
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_db;
    logic                   w_s;

    assign w_s  = r_sync[SYNC_STAGES-1];
    assign o_db = r_db;

    // Shift the raw level through the synchronizer chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_x};
        end
    end

    // Flip the debounced level only after it has disagreed for DEBOUNCE_CYCLES edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_db  <= 1'b0;
        end else if (w_s == r_db) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_db  <= w_s;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule : pb_debounce

// File: rtl/push_button_detector.sv
// Debounced push-button press detector: one z pulse per press.
module push_button_detector
    import push_button_detector_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    push_button_detector_if.slave   bus
);

    logic      w_db;
    pb_state_e r_state;
    pb_state_e w_next;

    pb_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .i_x   (bus.x),
        .o_db  (w_db)
    );

    // Press FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: pulse once on a debounced rise, then wait for release.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_db)  w_next = PULSE;
            PULSE:   w_next = w_db ? HELD : IDLE;
            HELD:    if (!w_db) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // z is a pure decode of the state flops, so it is glitch-free.
    assign bus.z = (r_state == PULSE);

endmodule : push_button_detector

// File: tb/tb_push_button_detector.sv
// Directed bench for push_button_detector with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_push_button_detector;

    logic clk;
    logic reset;

    push_button_detector_if u_if ();

    push_button_detector #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_total = 0;
    int   n_bad   = 0;
    int   edge_idx;
    int   pulse_cnt;
    int   wide_cnt;
    int   first_pulse;
    logic prev_z;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        edge_idx    = 0;
        pulse_cnt   = 0;
        wide_cnt    = 0;
        first_pulse = -1;
        prev_z      = 1'b0;
    endtask

    // Drive x at the falling edge, sample z 1 ns after the next rising edge.
    task automatic step(input logic v);
        @(negedge clk);
        u_if.x = v;
        @(posedge clk);
        #1;
        edge_idx++;
        if (u_if.z === 1'b1) begin
            pulse_cnt++;
            if (first_pulse < 0) first_pulse = edge_idx;
            if (prev_z) wide_cnt++;
        end
        prev_z = u_if.z;
    endtask

    task automatic hold(input logic v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    initial begin
        int found;
        reset  = 1'b0;
        u_if.x = 1'b0;
        clear_stats();

        // 1: reset held with random x, then release with x=0
        for (int i = 0; i < 5; i++) begin
            step(1'($urandom_range(0, 1)));
            chk("rst_z", int'(u_if.z), 0);
        end
        #1 reset = 1'b1;
        clear_stats();
        hold(1'b0, 10);
        chk("rst_release_no_pulse", pulse_cnt, 0);

        // 2: clean press, pulse on 7th edge, one cycle wide
        clear_stats();
        hold(1'b1, 50);
        chk("clean_first_edge", first_pulse, 7);
        chk("clean_pulse_cnt", pulse_cnt, 1);
        chk("clean_width", wide_cnt, 0);
        clear_stats();
        hold(1'b0, 10);
        chk("clean_release", pulse_cnt, 0);

        // 3: 3-cycle bounces are filtered, then a real press
        clear_stats();
        for (int i = 0; i < 5; i++) begin
            hold(1'b1, 3);
            hold(1'b0, 3);
        end
        chk("bounce_no_pulse", pulse_cnt, 0);
        clear_stats();
        hold(1'b1, 10);
        chk("bounce_press_cnt", pulse_cnt, 1);
        chk("bounce_press_edge", first_pulse, 7);

        // 4: short release glitch ignored, full release re-arms
        hold(1'b1, 10);
        clear_stats();
        hold(1'b0, 2);
        hold(1'b1, 20);
        chk("glitch_no_pulse", pulse_cnt, 0);
        clear_stats();
        hold(1'b0, 8);
        hold(1'b1, 12);
        chk("repress_cnt", pulse_cnt, 1);
        chk("repress_edge", first_pulse, 15);
        chk("repress_width", wide_cnt, 0);

        // 5: async reset while z=1, x held high through reset
        hold(1'b0, 8);
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            step(1'b1);
            if (u_if.z === 1'b1) found = 1;
        end
        chk("arst_pulse_seen", found, 1);
        #1 reset = 1'b0;
        #1 chk("arst_z_immediate", int'(u_if.z), 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            chk("arst_hold_z", int'(u_if.z), 0);
        end
        #1 reset = 1'b1;
        clear_stats();
        hold(1'b1, 20);
        chk("arst_repress_edge", first_pulse, 7);
        chk("arst_repress_cnt", pulse_cnt, 1);

        // 6: two long presses
        hold(1'b0, 10);
        clear_stats();
        hold(1'b1, 6000);
        hold(1'b0, 25);
        hold(1'b1, 600);
        hold(1'b0, 30);
        chk("long_pulse_cnt", pulse_cnt, 2);
        chk("long_width", wide_cnt, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_push_button_detector
